// File: rtl/uart_cmd_responder_if.sv
// Byte/strobe bundle between the UART pair, the responder and the register bus.
// The responder is the master; the surrounding UART and register logic is the slave.
interface uart_cmd_responder_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_idle;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       overrun;
    logic       busy;

    modport master (
        input  rx_valid, rx_byte, rx_idle, tx_ready, reg_rdata,
        output tx_start, tx_byte, reg_addr, reg_wdata, reg_we, reg_re, overrun, busy
    );

    modport slave (
        output rx_valid, rx_byte, rx_idle, tx_ready, reg_rdata,
        input  tx_start, tx_byte, reg_addr, reg_wdata, reg_we, reg_re, overrun, busy
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Host command responder: parses W/R frames from the UART receiver, drives the
// register bus and returns one response byte per command through the transmitter.
module uart_cmd_responder #(
    parameter logic [7:0] OP_WRITE = 8'h57,
    parameter logic [7:0] OP_READ  = 8'h52,
    parameter logic [7:0] RSP_ACK  = 8'h4B,
    parameter logic [7:0] RSP_NAK  = 8'h3F
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_cmd_responder_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, DO_WRITE, DO_READ,
        READ_WAIT, SEND, WAIT_BUSY, WAIT_DONE
    } state_t;

    state_t     state, stateNext;
    logic       isWrite, isWriteNext;
    logic       txStart, txStartNext;
    logic [7:0] txByte, txByteNext;
    logic [7:0] regAddr, regAddrNext;
    logic [7:0] regWdata, regWdataNext;
    logic       regWe, regWeNext;
    logic       regRe, regReNext;
    logic       overrunFlag, overrunNext;
    logic       busyFlag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            isWrite     <= 1'b0;
            txStart     <= 1'b0;
            txByte      <= 8'h00;
            regAddr     <= 8'h00;
            regWdata    <= 8'h00;
            regWe       <= 1'b0;
            regRe       <= 1'b0;
            overrunFlag <= 1'b0;
            busyFlag    <= 1'b0;
        end else begin
            state       <= stateNext;
            isWrite     <= isWriteNext;
            txStart     <= txStartNext;
            txByte      <= txByteNext;
            regAddr     <= regAddrNext;
            regWdata    <= regWdataNext;
            regWe       <= regWeNext;
            regRe       <= regReNext;
            overrunFlag <= overrunNext;
            busyFlag    <= (stateNext != IDLE);
        end
    end

    // Strobes are computed one state early so every output leaves a flop.
    always_comb begin
        stateNext    = state;
        isWriteNext  = isWrite;
        txStartNext  = 1'b0;
        txByteNext   = txByte;
        regAddrNext  = regAddr;
        regWdataNext = regWdata;
        regWeNext    = 1'b0;
        regReNext    = 1'b0;
        overrunNext  = overrunFlag;

        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    isWriteNext = (bus.rx_byte == OP_WRITE);
                    if (bus.rx_byte == OP_WRITE || bus.rx_byte == OP_READ) begin
                        stateNext = GET_ADDR;
                    end else begin
                        txByteNext = RSP_NAK;
                        stateNext  = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (bus.rx_valid) begin
                    regAddrNext = bus.rx_byte;
                    if (isWrite) begin
                        stateNext = GET_DATA;
                    end else begin
                        regReNext = 1'b1;
                        stateNext = DO_READ;
                    end
                end else if (bus.rx_idle) begin
                    stateNext = IDLE;
                end
            end
            GET_DATA: begin
                if (bus.rx_valid) begin
                    regWdataNext = bus.rx_byte;
                    regWeNext    = 1'b1;
                    stateNext    = DO_WRITE;
                end else if (bus.rx_idle) begin
                    stateNext = IDLE;
                end
            end
            DO_WRITE: begin
                txByteNext = RSP_ACK;
                stateNext  = SEND;
            end
            DO_READ: begin
                stateNext = READ_WAIT;
            end
            READ_WAIT: begin
                txByteNext = bus.reg_rdata;
                stateNext  = SEND;
            end
            SEND: begin
                if (bus.tx_ready) begin
                    txStartNext = 1'b1;
                    stateNext   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!bus.tx_ready) stateNext = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_ready) stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Bytes arriving while a command executes or its response drains are dropped.
        if (bus.rx_valid && (state inside {DO_WRITE, DO_READ, READ_WAIT, SEND, WAIT_BUSY, WAIT_DONE})) begin
            overrunNext = 1'b1;
        end
    end

    assign bus.tx_start  = txStart;
    assign bus.tx_byte   = txByte;
    assign bus.reg_addr  = regAddr;
    assign bus.reg_wdata = regWdata;
    assign bus.reg_we    = regWe;
    assign bus.reg_re    = regRe;
    assign bus.overrun   = overrunFlag;
    assign bus.busy      = busyFlag;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: commands queue their expected register
// strobes and response bytes; a negedge monitor pops and compares them.
module tb_uart_cmd_responder;

    localparam int K_NONE = 0;
    localparam int K_WE   = 1;
    localparam int K_RE   = 2;
    localparam int K_TX   = 3;

    typedef struct {
        int kind;
        int a;
        int b;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_cmd_responder_if bus();

    uart_cmd_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         lastCyc = 0;
    ev_t        q[$];
    int         txBusyCnt = 0;
    int         txLen = 3;
    logic       txBlock = 1'b0;
    logic [7:0] lastTx = 8'h00;

    logic [7:0] mem[256];
    bit         memWritten[256];
    logic [7:0] shadow[256];
    bit         shadowWritten[256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] initVal(input logic [7:0] a);
        return (a == 8'h22) ? 8'h3C : (a ^ 8'hA5);
    endfunction

    function automatic logic [7:0] expRead(input logic [7:0] a);
        return shadowWritten[a] ? shadow[a] : initVal(a);
    endfunction

    function automatic ev_t popEv();
        ev_t e;
        e.kind = K_NONE;
        e.a    = 0;
        e.b    = 0;
        e.cyc  = -1;
        if (q.size() > 0) e = q.pop_front();
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: drops tx_ready for txLen cycles after each launch.
    assign bus.tx_ready = !txBlock && (txBusyCnt == 0);
    always @(posedge clk or posedge rst) begin
        if (rst)                txBusyCnt <= 0;
        else if (txBusyCnt > 0) txBusyCnt <= txBusyCnt - 1;
        else if (bus.tx_start)  txBusyCnt <= txLen;
    end

    // Register file model: read data is valid only in the cycle after reg_re.
    always @(posedge clk) begin
        if (bus.reg_we) begin
            mem[bus.reg_addr]        <= bus.reg_wdata;
            memWritten[bus.reg_addr] <= 1'b1;
        end
        if (bus.reg_re)
            bus.reg_rdata <= memWritten[bus.reg_addr] ? mem[bus.reg_addr] : initVal(bus.reg_addr);
        else
            bus.reg_rdata <= 8'($urandom);
    end

    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (bus.reg_we || bus.reg_re) chk("we_re_excl", {31'd0, bus.reg_we & bus.reg_re}, 0);
            if (bus.reg_we) begin
                e = popEv();
                chk("we_kind", e.kind, K_WE);
                chk("we_addr", {24'd0, bus.reg_addr}, e.a);
                chk("we_data", {24'd0, bus.reg_wdata}, e.b);
                if (e.cyc >= 0) chk("we_lat", cyc, e.cyc);
            end
            if (bus.reg_re) begin
                e = popEv();
                chk("re_kind", e.kind, K_RE);
                chk("re_addr", {24'd0, bus.reg_addr}, e.a);
                if (e.cyc >= 0) chk("re_lat", cyc, e.cyc);
            end
            if (bus.tx_start) begin
                e = popEv();
                chk("tx_kind", e.kind, K_TX);
                chk("tx_byte", {24'd0, bus.tx_byte}, e.a);
                chk("tx_rdy", {31'd0, bus.tx_ready}, 1);
                if (e.cyc >= 0) chk("tx_lat", cyc, e.cyc);
                lastTx = bus.tx_byte;
            end else if (bus.busy && txBusyCnt > 0) begin
                chk("tx_hold", {24'd0, bus.tx_byte}, {24'd0, lastTx});
            end
        end
    end

    task automatic pushEv(input int k, input int a, input int b, input int c);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic idle = 1'b0);
        @(posedge clk);
        #1 bus.rx_valid = 1'b1;
        bus.rx_byte = b;
        bus.rx_idle = idle;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        bus.rx_idle = 1'b0;
        lastCyc = cyc;
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [7:0] d, input bit timed);
        sendByte(8'h57);
        sendByte(a);
        sendByte(d);
        shadow[a] = d;
        shadowWritten[a] = 1'b1;
        pushEv(K_WE, a, d, lastCyc);
        pushEv(K_TX, 8'h4B, 0, timed ? lastCyc + 2 : -1);
    endtask

    task automatic doRead(input logic [7:0] a);
        sendByte(8'h52);
        sendByte(a);
        pushEv(K_RE, a, 0, lastCyc);
        pushEv(K_TX, expRead(a), 0, lastCyc + 3);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < budget);
        chk(tag, {31'd0, bus.busy}, 0);
    endtask

    task automatic waitTxStart(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tx_start && n < 20);
        chk(tag, {31'd0, bus.tx_start}, 1);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_txs"},  {31'd0, bus.tx_start}, 0);
        chk({tag, "_txb"},  {24'd0, bus.tx_byte}, 0);
        chk({tag, "_addr"}, {24'd0, bus.reg_addr}, 0);
        chk({tag, "_wd"},   {24'd0, bus.reg_wdata}, 0);
        chk({tag, "_we"},   {31'd0, bus.reg_we}, 0);
        chk({tag, "_re"},   {31'd0, bus.reg_re}, 0);
        chk({tag, "_ovr"},  {31'd0, bus.overrun}, 0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.rx_idle  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chkAllZero("rst0");
        @(posedge clk);
        #1 rst = 1'b0;

        doWrite(8'h10, 8'hA5, 1'b1);
        waitIdle("wr_idle", 40);

        doRead(8'h22);
        waitIdle("rd_idle", 40);

        sendByte(8'h41);
        pushEv(K_TX, 8'h3F, 0, lastCyc + 1);
        waitIdle("nak_idle", 40);

        // Abort from GET_DATA, then from GET_ADDR.
        sendByte(8'h57);
        sendByte(8'h10);
        @(posedge clk);
        #1 bus.rx_idle = 1'b1;
        @(posedge clk);
        #1 bus.rx_idle = 1'b0;
        @(negedge clk);
        chk("abort_data", {31'd0, bus.busy}, 0);
        sendByte(8'h52);
        @(posedge clk);
        #1 bus.rx_idle = 1'b1;
        @(posedge clk);
        #1 bus.rx_idle = 1'b0;
        @(negedge clk);
        chk("abort_addr", {31'd0, bus.busy}, 0);
        doRead(8'h05);
        waitIdle("abort_rd_idle", 40);

        // rx_valid wins over a simultaneous rx_idle.
        sendByte(8'h57);
        sendByte(8'h33, 1'b1);
        sendByte(8'hC7, 1'b1);
        shadow[8'h33] = 8'hC7;
        shadowWritten[8'h33] = 1'b1;
        pushEv(K_WE, 8'h33, 8'hC7, lastCyc);
        pushEv(K_TX, 8'h4B, 0, lastCyc + 2);
        waitIdle("simul_idle", 40);

        doRead(8'h10);
        waitIdle("rb10_idle", 40);
        doRead(8'h33);
        waitIdle("rb33_idle", 40);

        // Transmitter not ready: the response must wait in SEND.
        txBlock = 1'b1;
        doWrite(8'h44, 8'h5E, 1'b0);
        repeat (20) @(negedge clk);
        chk("hold_busy", {31'd0, bus.busy}, 1);
        chk("hold_pend", q.size(), 1);
        txBlock = 1'b0;
        waitIdle("hold_idle", 40);

        // Overrun during a long transmit.
        txLen = 50;
        doWrite(8'h55, 8'h66, 1'b1);
        waitTxStart("ovr_txs");
        chk("ovr_pre", {31'd0, bus.overrun}, 0);
        sendByte(8'h99);
        @(negedge clk);
        chk("ovr_set", {31'd0, bus.overrun}, 1);
        waitIdle("ovr_idle", 200);
        txLen = 3;
        doRead(8'h55);
        waitIdle("ovr_rd_idle", 40);
        chk("ovr_sticky", {31'd0, bus.overrun}, 1);

        // Reset in GET_DATA.
        sendByte(8'h57);
        sendByte(8'h77);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chkAllZero("rstA");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstA_post", {31'd0, bus.busy}, 0);

        // Reset in WAIT_BUSY.
        txLen = 20;
        doWrite(8'h12, 8'h34, 1'b1);
        waitTxStart("rstB_txs");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chkAllZero("rstB");
        @(posedge clk);
        #1 rst = 1'b0;
        txLen = 3;
        repeat (5) @(negedge clk);
        chk("rstB_post", {31'd0, bus.busy}, 0);

        doWrite(8'h20, 8'hBE, 1'b1);
        waitIdle("post_wr_idle", 40);
        doRead(8'h20);
        waitIdle("post_rd_idle", 40);
        doRead(8'h12);
        waitIdle("post_rd12_idle", 40);

        repeat (3) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
